// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: core has priority, return-stack (ras) is protected from starvation.
// Optional watchdog abort of a stalled transaction is enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        core_rea,
    input  logic        core_wea,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_din,
    input  logic [2:0]  core_storecntrl,
    output logic [31:0] core_dout,
    output logic        core_hold,
    input  logic        ras_rd,
    input  logic        ras_wr,
    input  logic [31:0] ras_addr,
    input  logic [31:0] ras_din,
    output logic [31:0] ras_dout,
    output logic        ras_rdy,
    output logic        mem_en,
    output logic        mem_wea,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_storecntrl,
    input  logic [31:0] mem_dout,
    input  logic        mem_rdy,
    output logic        arb_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_BUSY = 2'd1,
        RAS_BUSY  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant_core;
    logic          w_grant_ras;
    logic          w_core_req;
    logic          w_ras_req;
    logic          w_core_ok;
    logic          w_ras_ok;
    logic          w_starved;
    logic          w_finish;
    logic          w_timeout;
    logic          w_err_evt;
    logic [31:0]   w_fin_data;
    logic [SW-1:0] r_starve;
    logic          r_core_done;
    logic          r_ras_rdy;
    logic [31:0]   r_core_dout;
    logic [31:0]   r_ras_dout;
    logic          r_mem_en;
    logic          r_mem_wea;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_din;
    logic [2:0]    r_mem_sc;
    logic          r_arb_err;

    // A requester is masked in the cycle right after its completion, while it still shows the old request.
    assign w_core_req = core_rea | core_wea;
    assign w_ras_req  = ras_rd | ras_wr;
    assign w_core_ok  = w_core_req & ~r_core_done;
    assign w_ras_ok   = w_ras_req & ~r_ras_rdy;
    assign w_starved  = (r_starve >= SW'(STARVE_LIMIT));
    assign w_finish   = mem_rdy | w_timeout;
    assign w_fin_data = mem_rdy ? mem_dout : 32'h0000_0000;
    assign w_err_evt  = ((r_state == IDLE) & mem_rdy) | (ras_rd & ras_wr) | w_timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_wd;

    assign w_timeout = (r_state != IDLE) & ~mem_rdy & (r_wd == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts busy cycles, restarted whenever the arbiter is idle.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_wd <= {TW{1'b0}};
        end else if (r_state == IDLE) begin
            r_wd <= {TW{1'b0}};
        end else begin
            r_wd <= r_wd + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Hold follows the live request so the core stalls in the very cycle it asks; forced low in reset.
    assign core_hold = Rst & w_core_req & ~r_core_done;

    // Next-state and grant decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_core = 1'b0;
        w_grant_ras  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ras_ok && (!w_core_req || w_starved)) begin
                    w_grant_ras = 1'b1;
                    w_state_nxt = RAS_BUSY;
                end else if (w_core_ok) begin
                    w_grant_core = 1'b1;
                    w_state_nxt  = CORE_BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CORE_BUSY, RAS_BUSY: begin
                if (w_finish) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory command: strobe for one cycle, command fields stay latched until the next grant.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_mem_en   <= 1'b0;
            r_mem_wea  <= 1'b0;
            r_mem_addr <= 32'h0000_0000;
            r_mem_din  <= 32'h0000_0000;
            r_mem_sc   <= 3'b000;
        end else if (w_grant_core) begin
            r_mem_en   <= 1'b1;
            r_mem_wea  <= core_wea;
            r_mem_addr <= core_addr;
            r_mem_din  <= core_din;
            r_mem_sc   <= core_storecntrl;
        end else if (w_grant_ras) begin
            r_mem_en   <= 1'b1;
            r_mem_wea  <= ras_wr;
            r_mem_addr <= ras_addr;
            r_mem_din  <= ras_din;
            r_mem_sc   <= 3'b010;
        end else begin
            r_mem_en   <= 1'b0;
        end
    end

    // Completion: capture read data and raise the one-cycle done indications.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_core_done <= 1'b0;
            r_ras_rdy   <= 1'b0;
            r_core_dout <= 32'h0000_0000;
            r_ras_dout  <= 32'h0000_0000;
        end else begin
            r_core_done <= (r_state == CORE_BUSY) & w_finish;
            r_ras_rdy   <= (r_state == RAS_BUSY) & w_finish;
            if ((r_state == CORE_BUSY) && w_finish) begin
                r_core_dout <= w_fin_data;
            end else begin
                r_core_dout <= r_core_dout;
            end
            if ((r_state == RAS_BUSY) && w_finish) begin
                r_ras_dout <= w_fin_data;
            end else begin
                r_ras_dout <= r_ras_dout;
            end
        end
    end

    // Starvation counter: consecutive core grants while ras keeps waiting, saturating.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_starve <= {SW{1'b0}};
        end else if (w_grant_ras || !w_ras_req) begin
            r_starve <= {SW{1'b0}};
        end else if (w_grant_core && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_arb_err <= 1'b0;
        end else if (w_err_evt) begin
            r_arb_err <= 1'b1;
        end else begin
            r_arb_err <= r_arb_err;
        end
    end

    assign core_dout      = r_core_dout;
    assign ras_dout       = r_ras_dout;
    assign ras_rdy        = r_ras_rdy;
    assign mem_en         = r_mem_en;
    assign mem_wea        = r_mem_wea;
    assign mem_addr       = r_mem_addr;
    assign mem_din        = r_mem_din;
    assign mem_storecntrl = r_mem_sc;
    assign arb_err        = r_arb_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences for
// starvation, reset abandonment, request encoding and the (optional) watchdog.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        core_rea, core_wea, ras_rd, ras_wr, mem_rdy;
    logic [31:0] core_addr, core_din, ras_addr, ras_din, mem_dout;
    logic [2:0]  core_storecntrl;
    logic [31:0] core_dout, ras_dout, mem_addr, mem_din;
    logic        core_hold, ras_rdy, mem_en, mem_wea, arb_err;
    logic [2:0]  mem_storecntrl;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .Rst(Rst),
        .core_rea(core_rea), .core_wea(core_wea), .core_addr(core_addr), .core_din(core_din),
        .core_storecntrl(core_storecntrl), .core_dout(core_dout), .core_hold(core_hold),
        .ras_rd(ras_rd), .ras_wr(ras_wr), .ras_addr(ras_addr), .ras_din(ras_din),
        .ras_dout(ras_dout), .ras_rdy(ras_rdy),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_storecntrl(mem_storecntrl), .mem_dout(mem_dout), .mem_rdy(mem_rdy), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        crea, cwea;
        logic [31:0] caddr, cdin;
        logic [2:0]  csc;
        logic        rrd, rwr;
        logic [31:0] raddr, rdin;
        logic        mrdy;
        logic [31:0] mdout;
        logic [135:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic crea, cwea, input logic [31:0] caddr, cdin, input logic [2:0] csc,
                                input logic rrd, rwr, input logic [31:0] raddr, rdin,
                                input logic mrdy, input logic [31:0] mdout,
                                input logic een, ewea, input logic [31:0] eaddr, edin, input logic [2:0] esc,
                                input logic ehold, input logic [31:0] ecd, input logic errdy,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.crea = crea; v.cwea = cwea; v.caddr = caddr; v.cdin = cdin; v.csc = csc;
        v.rrd = rrd; v.rwr = rwr; v.raddr = raddr; v.rdin = rdin;
        v.mrdy = mrdy; v.mdout = mdout;
        v.exp = {een, ewea, eaddr, edin, esc, ehold, ecd, errdy, erd, eerr};
        return v;
    endfunction

    function automatic logic [135:0] outs();
        return {mem_en, mem_wea, mem_addr, mem_din, mem_storecntrl, core_hold, core_dout, ras_rdy, ras_dout, arb_err};
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        core_rea = 1'b0; core_wea = 1'b0; core_addr = 32'h0; core_din = 32'h0; core_storecntrl = 3'b000;
        ras_rd = 1'b0; ras_wr = 1'b0; ras_addr = 32'h0; ras_din = 32'h0;
        mem_rdy = 1'b0; mem_dout = 32'h0;
    endtask

    task automatic do_reset(input string name);
        Rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk(name, outs(), 136'h0);
        Rst = 1'b1;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (mem_en) ok = 1'b1;
        end
    endtask

    task automatic pulse_rdy(input logic [31:0] data);
        mem_rdy = 1'b1;
        mem_dout = data;
        @(posedge clk);
        #1;
        mem_rdy = 1'b0;
        mem_dout = 32'h0;
    endtask

    vec_t vecs[15];

    initial begin
        bit ok;
        int n_core;
        bit ras_seen;
        int cyc;
        int extra_en;

        // core read 0x100, then simultaneous core write / ras read
        vecs[0]  = mk(1'b1,1'b0,32'h100,32'h0,3'b010, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,3'b000, 1'b1,32'h0,1'b0,32'h0,1'b0);
        vecs[1]  = mk(1'b1,1'b0,32'h100,32'h0,3'b010, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b1,1'b0,32'h100,32'h0,3'b010, 1'b1,32'h0,1'b0,32'h0,1'b0);
        vecs[2]  = mk(1'b1,1'b0,32'h100,32'h0,3'b010, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h100,32'h0,3'b010, 1'b1,32'h0,1'b0,32'h0,1'b0);
        vecs[3]  = mk(1'b1,1'b0,32'h100,32'h0,3'b010, 1'b0,1'b0,32'h0,32'h0, 1'b1,32'hDEADBEEF, 1'b0,1'b0,32'h100,32'h0,3'b010, 1'b1,32'h0,1'b0,32'h0,1'b0);
        vecs[4]  = mk(1'b1,1'b0,32'h100,32'h0,3'b010, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h100,32'h0,3'b010, 1'b0,32'hDEADBEEF,1'b0,32'h0,1'b0);
        vecs[5]  = mk(1'b0,1'b0,32'h100,32'h0,3'b010, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h100,32'h0,3'b010, 1'b0,32'hDEADBEEF,1'b0,32'h0,1'b0);
        vecs[6]  = mk(1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b0,1'b0,32'h100,32'h0,3'b010, 1'b1,32'hDEADBEEF,1'b0,32'h0,1'b0);
        vecs[7]  = mk(1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b1,1'b1,32'h200,32'h11112222,3'b001, 1'b1,32'hDEADBEEF,1'b0,32'h0,1'b0);
        vecs[8]  = mk(1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b1,32'h12345678, 1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b1,32'hDEADBEEF,1'b0,32'h0,1'b0);
        vecs[9]  = mk(1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b0,32'h12345678,1'b0,32'h0,1'b0);
        vecs[10] = mk(1'b0,1'b0,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b0,1'b1,32'h200,32'h11112222,3'b001, 1'b0,32'h12345678,1'b0,32'h0,1'b0);
        vecs[11] = mk(1'b0,1'b0,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b1,1'b0,32'h300,32'h55AA55AA,3'b010, 1'b0,32'h12345678,1'b0,32'h0,1'b0);
        vecs[12] = mk(1'b0,1'b0,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b1,32'hCAFEF00D, 1'b0,1'b0,32'h300,32'h55AA55AA,3'b010, 1'b0,32'h12345678,1'b0,32'h0,1'b0);
        vecs[13] = mk(1'b0,1'b0,32'h200,32'h11112222,3'b001, 1'b1,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b0,1'b0,32'h300,32'h55AA55AA,3'b010, 1'b0,32'h12345678,1'b1,32'hCAFEF00D,1'b0);
        vecs[14] = mk(1'b0,1'b0,32'h200,32'h11112222,3'b001, 1'b0,1'b0,32'h300,32'h55AA55AA, 1'b0,32'h0, 1'b0,1'b0,32'h300,32'h55AA55AA,3'b010, 1'b0,32'h12345678,1'b0,32'hCAFEF00D,1'b0);

        do_reset("reset_state");

        for (int k = 0; k < 15; k++) begin
            core_rea = vecs[k].crea; core_wea = vecs[k].cwea; core_addr = vecs[k].caddr;
            core_din = vecs[k].cdin; core_storecntrl = vecs[k].csc;
            ras_rd = vecs[k].rrd; ras_wr = vecs[k].rwr; ras_addr = vecs[k].raddr; ras_din = vecs[k].rdin;
            mem_rdy = vecs[k].mrdy; mem_dout = vecs[k].mdout;
            #2;
            chk($sformatf("vec%0d", k), outs(), vecs[k].exp);
            @(posedge clk);
            #1;
        end
        clear_inputs();

        // continuous core requests against a waiting ras write
        core_rea = 1'b1; core_addr = 32'h400; core_storecntrl = 3'b010;
        ras_wr = 1'b1; ras_addr = 32'h500; ras_din = 32'h77;
        n_core = 0;
        ras_seen = 1'b0;
        for (int g = 0; g < 8 && !ras_seen; g++) begin
            wait_en(ok);
            if (!ok) begin
                chk("starve_en_timeout", 136'h0, 136'h1);
                break;
            end
            if (mem_addr == 32'h500) begin
                ras_seen = 1'b1;
                chk("starve_ras_cmd", {133'h0, mem_wea, mem_storecntrl}, {133'h0, 1'b1, 3'b010});
                core_rea = 1'b0;
                pulse_rdy(32'hA5A5A5A5);
            end else begin
                n_core++;
                pulse_rdy(32'h1000 + g);
            end
        end
        chk("starve_core_grants", {135'h0, ras_seen} | (136'(n_core) << 8), {135'h0, 1'b1} | (136'(4) << 8));
        chk("starve_ras_done", {103'h0, ras_rdy, ras_dout}, {103'h0, 1'b1, 32'hA5A5A5A5});
        ras_wr = 1'b0;
        @(posedge clk);
        #1;

        // reset in CORE_BUSY abandons the transfer; late mem_rdy is an error
        core_rea = 1'b1; core_addr = 32'h600;
        wait_en(ok);
        chk("rst_busy_grant", {135'h0, ok}, {135'h0, 1'b1});
        @(posedge clk);
        #1;
        Rst = 1'b0;
        core_rea = 1'b0;
        #1;
        chk("rst_outputs_zero", outs(), 136'h0);
        repeat (2) @(posedge clk);
        #1;
        Rst = 1'b1;
        @(posedge clk);
        #1;
        pulse_rdy(32'hFFFFFFFF);
        extra_en = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_en) extra_en++;
            @(posedge clk);
            #1;
        end
        chk("late_rdy", {71'h0, arb_err, core_dout, core_hold, 32'(extra_en)},
                        {71'h0, 1'b1, 32'h0, 1'b0, 32'h0});

        // core read+write together is a plain write, no error
        do_reset("reset2_state");
        core_rea = 1'b1; core_wea = 1'b1; core_addr = 32'h700; core_din = 32'h99; core_storecntrl = 3'b000;
        wait_en(ok);
        chk("core_rw_as_write", {70'h0, ok, mem_wea, mem_addr, mem_din, arb_err},
                                {70'h0, 1'b1, 1'b1, 32'h700, 32'h99, 1'b0});
        pulse_rdy(32'h0);
        core_rea = 1'b0; core_wea = 1'b0;
        @(posedge clk);
        #1;

        ras_rd = 1'b1; ras_addr = 32'h800;
        wait_en(ok);
        pulse_rdy(32'h1234);
        chk("ras_read", {102'h0, ok, ras_rdy, ras_dout}, {102'h0, 1'b1, 1'b1, 32'h1234});
        ras_rd = 1'b0;
        @(posedge clk);
        #1;

        // stalled memory: watchdog abort when enabled, indefinite wait otherwise
        ras_rd = 1'b1; ras_addr = 32'h900;
        wait_en(ok);
        chk("wd_grant", {135'h0, ok}, {135'h0, 1'b1});
        cyc = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ras_rdy) break;
        end
        chk("wd_abort", {70'h0, 32'(cyc), ras_rdy, ras_dout, arb_err},
                        {70'h0, 32'(64), 1'b1, 32'h0, 1'b1});
        ras_rd = 1'b0;
`else
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (ras_rdy || mem_en) cyc++;
        end
        chk("no_wd_wait", {70'h0, 32'(cyc), arb_err}, {70'h0, 32'h0, 1'b0});
        pulse_rdy(32'h5678);
        chk("no_wd_finish", {103'h0, ras_rdy, ras_dout}, {103'h0, 1'b1, 32'h5678});
        ras_rd = 1'b0;
`endif
        @(posedge clk);
        #1;

        // ras read+write together: write command and sticky error
        do_reset("reset3_state");
        ras_rd = 1'b1; ras_wr = 1'b1; ras_addr = 32'hA00; ras_din = 32'h42;
        wait_en(ok);
        chk("ras_rw_err", {68'h0, ok, mem_wea, mem_addr, mem_din, mem_storecntrl, arb_err},
                          {68'h0, 1'b1, 1'b1, 32'hA00, 32'h42, 3'b010, 1'b1});
        pulse_rdy(32'h0);
        ras_rd = 1'b0; ras_wr = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
